// File: rtl/uart_pkg.sv
// Shared constants for the UART byte receiver: FSM state encodings,
// frame bit count and the baud divider calculation.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_START     = 3'd1;
  localparam state_t ST_DATA      = 3'd2;
  localparam state_t ST_PARITY    = 3'd3;
  localparam state_t ST_STOP      = 3'd4;
  localparam state_t ST_WAIT_HIGH = 3'd5;

  localparam int NUM_BITS = 8;

  // Clocks per oversample tick, truncating integer division.
  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    return clk_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: a down-counter that pulses tick for one clk
// every DIV clocks. restart reloads the counter so the first tick after a
// restart lands exactly DIV clocks later.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] RELOAD = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Count down to terminal zero, then reload; restart forces a reload.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= RELOAD;
    end else if (restart || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver, 8 data bits LSB first, one stop bit.
// Optional even-parity bit is enabled with `define UART_PARITY_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a synchronized falling edge
// START     | counting to start-bit midpoint; high there means glitch
// DATA      | sampling 8 data bits at bit midpoints, LSB first
// PARITY    | sampling even-parity bit (UART_PARITY_EN only)
// STOP      | sampling stop bit; high = byte out, low = framing error
// WAIT_HIGH | after framing error, hold until line returns high
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       posalji,
  output logic       busy,
  output logic       frame_err,
  output logic       par_err
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(NUM_BITS - 1);

  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  state_t        state;
  logic [TW-1:0] ticks_left;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          restart;
  logic          tick;
`ifdef UART_PARITY_EN
  logic          par_bad;
`endif

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // A falling edge in IDLE starts a frame and realigns the tick phase.
  assign restart = (state == ST_IDLE) && rx_prev && !rx_sync;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  // Frame FSM; ticks_left counts down ticks to the next sample point.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ticks_left <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      dout       <= '0;
      posalji    <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      par_err    <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      posalji   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      par_err   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (restart) begin
            state      <= ST_START;
            busy       <= 1'b1;
            ticks_left <= HALF_M1;
            bit_cnt    <= '0;
          end
        end

        ST_START: begin
          if (tick) begin
            if (ticks_left != '0) begin
              ticks_left <= ticks_left - 1'b1;
            end else if (!rx_sync) begin
              state      <= ST_DATA;
              ticks_left <= FULL_M1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (ticks_left != '0) begin
              ticks_left <= ticks_left - 1'b1;
            end else begin
              shift      <= {rx_sync, shift[7:1]};
              ticks_left <= FULL_M1;
              bit_cnt    <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end
            end
          end
        end

`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            if (ticks_left != '0) begin
              ticks_left <= ticks_left - 1'b1;
            end else begin
              // Even parity: data bits plus parity bit must XOR to zero.
              par_bad    <= (^shift) ^ rx_sync;
              ticks_left <= FULL_M1;
              state      <= ST_STOP;
            end
          end
        end
`endif

        ST_STOP: begin
          if (tick) begin
            if (ticks_left != '0) begin
              ticks_left <= ticks_left - 1'b1;
            end else if (rx_sync) begin
              // Back to IDLE at stop midpoint so the next start bit is seen.
              state <= ST_IDLE;
              busy  <= 1'b0;
`ifdef UART_PARITY_EN
              if (par_bad) begin
                par_err <= 1'b1;
              end else begin
                dout    <= shift;
                posalji <= 1'b1;
              end
`else
              dout    <= shift;
              posalji <= 1'b1;
`endif
            end else begin
              state     <= ST_WAIT_HIGH;
              busy      <= 1'b0;
              frame_err <= 1'b1;
            end
          end
        end

        ST_WAIT_HIGH: begin
          if (rx_sync) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_PARITY_EN
  assign par_err = 1'b0;
`endif

endmodule
